// File: rtl/p_accumulator.sv
// 48-bit accumulator with load/add/subtract/hold, pattern-detect autoreset and
// an optional saturation state machine compiled in by P_ACC_SATURATE_EN.
module p_accumulator #(
  parameter int unsigned AUTORESET_PATDET = 0,
  parameter logic [47:0] ACC_INIT         = 48'h0
) (
  input  logic        clk,
  input  logic        RSTP,
  input  logic        CEP,
  input  logic [1:0]  OPMODE,
  input  logic [47:0] D,
  input  logic        PATTERNDETECT,
  input  logic        PATTERNBDETECT,
  input  logic        OVERFLOW,
  input  logic        UNDERFLOW,
  output logic [47:0] P,
  output logic        CARRYOUT,
  output logic [1:0]  SAT,
  output logic [7:0]  ACC_CNT
);

  // No valid/ready handshake: CEP qualifies every update, and outputs are
  // registered values that are valid on every cycle after reset.

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  localparam logic [1:0] SAT_NORMAL = 2'b00;
  localparam logic [1:0] SAT_POS    = 2'b01;
  localparam logic [1:0] SAT_NEG    = 2'b10;

  localparam logic [47:0] P_MAX_POS = 48'h7FFF_FFFF_FFFF;
  localparam logic [47:0] P_MAX_NEG = 48'h8000_0000_0000;

  logic [47:0] p_q;
  logic        carry_q;
  logic [7:0]  cnt_q;
  logic        pd_past_q;

  logic        autoreset;
  logic [48:0] sum;
  logic [48:0] diff;
  logic [7:0]  cnt_inc;

  logic [47:0] op_p;
  logic        op_carry;
  logic [7:0]  op_cnt;

  logic [47:0] nxt_p;
  logic        nxt_carry;
  logic [7:0]  nxt_cnt;

  logic        unused_inputs;

  always_comb begin
    case (AUTORESET_PATDET)
      1:       autoreset = PATTERNDETECT;
      2:       autoreset = pd_past_q & ~PATTERNDETECT;
      default: autoreset = 1'b0;
    endcase
  end

  // Bit 48 of the widened difference is set exactly when p_q < D (borrow).
  assign sum     = {1'b0, p_q} + {1'b0, D};
  assign diff    = {1'b0, p_q} - {1'b0, D};
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    op_p     = p_q;
    op_carry = carry_q;
    op_cnt   = cnt_q;
    case (OPMODE)
      OP_LOAD: begin
        op_p     = D;
        op_carry = 1'b0;
        op_cnt   = 8'd0;
      end
      OP_ADD: begin
        op_p     = sum[47:0];
        op_carry = sum[48];
        op_cnt   = cnt_inc;
      end
      OP_SUB: begin
        op_p     = diff[47:0];
        op_carry = diff[48];
        op_cnt   = cnt_inc;
      end
      default: ;
    endcase
  end

`ifdef P_ACC_SATURATE_EN
  logic [1:0] sat_q;
  logic [1:0] sat_d;

  always_ff @(posedge clk) begin
    if (RSTP) begin
      sat_q <= SAT_NORMAL;
    end else if (CEP) begin
      sat_q <= sat_d;
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (autoreset) begin
      sat_d = SAT_NORMAL;
    end else begin
      case (sat_q)
        SAT_NORMAL: begin
          if (OVERFLOW) begin
            sat_d = SAT_POS;
          end else if (UNDERFLOW) begin
            sat_d = SAT_NEG;
          end
        end
        SAT_POS, SAT_NEG: begin
          if (OPMODE == OP_LOAD) begin
            sat_d = SAT_NORMAL;
          end
        end
        default: sat_d = SAT_NORMAL;
      endcase
    end
  end

  // While saturated only load escapes; add/subtract re-force the rail value.
  always_comb begin
    nxt_p     = op_p;
    nxt_carry = op_carry;
    nxt_cnt   = op_cnt;
    if (autoreset) begin
      nxt_p     = ACC_INIT;
      nxt_carry = 1'b0;
      nxt_cnt   = 8'd0;
    end else begin
      case (sat_q)
        SAT_NORMAL: begin
          if (OVERFLOW || UNDERFLOW) begin
            nxt_p     = OVERFLOW ? P_MAX_POS : P_MAX_NEG;
            nxt_carry = carry_q;
            nxt_cnt   = cnt_q;
          end
        end
        SAT_POS, SAT_NEG: begin
          if (OPMODE == OP_ADD || OPMODE == OP_SUB) begin
            nxt_p     = (sat_q == SAT_POS) ? P_MAX_POS : P_MAX_NEG;
            nxt_carry = carry_q;
            nxt_cnt   = cnt_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign SAT           = sat_q;
  assign unused_inputs = PATTERNBDETECT;
`else
  always_comb begin
    nxt_p     = op_p;
    nxt_carry = op_carry;
    nxt_cnt   = op_cnt;
    if (autoreset) begin
      nxt_p     = ACC_INIT;
      nxt_carry = 1'b0;
      nxt_cnt   = 8'd0;
    end
  end

  assign SAT           = SAT_NORMAL;
  assign unused_inputs = ^{PATTERNBDETECT, OVERFLOW, UNDERFLOW, P_MAX_POS, P_MAX_NEG,
                           SAT_POS, SAT_NEG, OP_HOLD};
`endif

  always_ff @(posedge clk) begin
    if (RSTP) begin
      p_q       <= ACC_INIT;
      carry_q   <= 1'b0;
      cnt_q     <= 8'd0;
      pd_past_q <= 1'b0;
    end else if (CEP) begin
      p_q       <= nxt_p;
      carry_q   <= nxt_carry;
      cnt_q     <= nxt_cnt;
      pd_past_q <= PATTERNDETECT;
    end
  end

  assign P        = p_q;
  assign CARRYOUT = carry_q;
  assign ACC_CNT  = cnt_q;

endmodule

// File: doc/p_accumulator.md
P_ACCUMULATOR -- requirements
Module: p_accumulator

Interface
REQ-001 SHALL have parameter AUTORESET_PATDET, default 0: 0 NO_RESET, 1 RESET_MATCH, 2 RESET_NOT_MATCH.
REQ-002 SHALL have parameter ACC_INIT, default 48'h0: value P takes on reset, autoreset and load-of-init.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-004 SHALL have port RSTP, input, 1, synchronous active-high reset; it has priority over CEP.
REQ-005 SHALL have port CEP, input, 1, clock enable for P and all internal state.
REQ-006 SHALL have port OPMODE, input, 2: 00 load, 01 add, 10 subtract, 11 hold.
REQ-007 SHALL have port D, input, 48, operand.
REQ-008 SHALL have ports PATTERNDETECT and PATTERNBDETECT, each input, 1, detector flags evaluated on the current P.
REQ-009 SHALL have ports OVERFLOW and UNDERFLOW, each input, 1, detector flags for the current P.
REQ-010 SHALL have port P, output, 48, registered accumulator value.
REQ-011 SHALL have port CARRYOUT, output, 1, registered carry/borrow of the last add/subtract.
REQ-012 SHALL have port SAT, output, 2, saturation state: 00 NORMAL, 01 SAT_POS, 10 SAT_NEG.
REQ-013 SHALL have port ACC_CNT, output, 8, count of add/subtract updates since the last clear, saturating at 255.

Function
REQ-014 SHALL perform all updates on the posedge of clk only when CEP=1; with CEP=0, P, CARRYOUT, SAT, ACC_CNT and the past-match register SHALL hold.
REQ-015 SHALL use update priority, highest first: RSTP, then autoreset, then saturation, then OPMODE.
REQ-016 SHALL, with OPMODE 00, set P<=D, CARRYOUT<=0 and ACC_CNT<=0.
REQ-017 SHALL, with OPMODE 01, set P<=P+D mod 2^48 and CARRYOUT<=bit 48 of the 49-bit sum.
REQ-018 SHALL, with OPMODE 10, set P<=P-D mod 2^48 and CARRYOUT<=1 when a borrow occurs (P<D unsigned).
REQ-019 SHALL, with OPMODE 11, hold P and CARRYOUT.
REQ-020 SHALL increment ACC_CNT on every executed add or subtract and hold it at 255 once 255 is reached.
REQ-021 SHALL keep internal register pd_past, which captures PATTERNDETECT on every CEP edge; it is cleared by RSTP.
REQ-022 SHALL, in mode 1 (RESET_MATCH), autoreset when PATTERNDETECT=1.
REQ-023 SHALL, in mode 2 (RESET_NOT_MATCH), autoreset when pd_past=1 and PATTERNDETECT=0.
REQ-024 SHALL, in mode 0, never autoreset.
REQ-025 SHALL, on autoreset, set P<=ACC_INIT, CARRYOUT<=0, ACC_CNT<=0 and SAT<=NORMAL one cycle after the triggering flag, overriding OPMODE.
REQ-026 SHALL treat the SAT state machine as follows, compiled in only per REQ-031:
- NORMAL to SAT_POS on OVERFLOW=1.
- NORMAL to SAT_NEG on UNDERFLOW=1.
- If both flags are asserted, OVERFLOW wins.
REQ-027 SHALL, in SAT_POS, force P<=48'h7FFF_FFFF_FFFF every CEP cycle; in SAT_NEG, force P<=48'h8000_0000_0000; add/subtract SHALL be ignored and ACC_CNT held.
REQ-028 SHALL exit SAT_POS or SAT_NEG to NORMAL only on RSTP, autoreset, or OPMODE 00 (load executes that cycle).
REQ-029 SHALL hold P and SAT unchanged on OPMODE 11 while saturated.

Reset
REQ-030 SHALL, on RSTP=1 at posedge (regardless of CEP), set P=ACC_INIT, CARRYOUT=0, SAT=00, ACC_CNT=0 and pd_past=0; reset mid-accumulation or mid-saturation SHALL discard all state.

Configuration
REQ-031 SHALL compile the saturation state machine (REQ-026 to REQ-029) only when macro P_ACC_SATURATE_EN is defined; when it is undefined, OVERFLOW and UNDERFLOW SHALL be ignored, SAT SHALL be tied to 00, and P SHALL wrap modulo 2^48.

Verification
REQ-032 SHALL cover: RSTP=1, then load D=5, then 3 adds of D=10 -> P=5,15,25,35; ACC_CNT=3; CARRYOUT=0.
REQ-033 SHALL cover: P=48'hFFFF_FFFF_FFFF, add D=1 -> P=0, CARRYOUT=1; then subtract D=1 -> P=48'hFFFF_FFFF_FFFF, CARRYOUT=1.
REQ-034 SHALL cover: mode 1, PATTERNDETECT=1 for one cycle with OPMODE=01 -> next P=ACC_INIT and ACC_CNT=0; CEP=0 on that cycle -> no change.
REQ-035 SHALL cover: mode 2, PATTERNDETECT sequence 1,1,0 -> autoreset only after the 1-to-0 transition; sequence 0,0 -> no autoreset.
REQ-036 SHALL cover: with P_ACC_SATURATE_EN, OVERFLOW=1 -> P=48'h7FFF_FFFF_FFFF and SAT=01; 3 adds -> P unchanged; load D=7 -> P=7, SAT=00; without the macro, the same stimulus leaves SAT=00 and P follows wrap arithmetic.
REQ-037 SHALL cover: OVERFLOW and UNDERFLOW asserted together -> SAT=01; RSTP asserted while saturated -> SAT=00 and P=ACC_INIT.
